// File: rtl/bank_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bank_mem_pkg
// Purpose  : Shared constants, request-class encoding and helper functions
//            for the four-bank word-interleaved memory responder.
// Contents : NUM_BANKS, RD_LATENCY, req_class_e, bank_sel(), classify()
// Revision : 1.0 - initial release
// ============================================================================
package bank_mem_pkg;

    localparam int NUM_BANKS  = 4;
    localparam int RD_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LEGAL_RD = 2'd1,
        LEGAL_WR = 2'd2,
        ILLEGAL  = 2'd3
    } req_class_e;

    // Word-interleaved banking: consecutive 16-bit words land in
    // consecutive banks, so the bank is the word index modulo 4.
    function automatic logic [1:0] bank_sel(input logic [2:0] addr_lo);
        return addr_lo[2:1];
    endfunction

    // Both strobes at once, or any strobe to an odd byte address, is illegal.
    function automatic req_class_e classify(input logic rd,
                                            input logic wr,
                                            input logic addr0);
        req_class_e cls;
        if (!rd && !wr) begin
            cls = IDLE;
        end else if ((rd && wr) || addr0) begin
            cls = ILLEGAL;
        end else if (rd) begin
            cls = LEGAL_RD;
        end else begin
            cls = LEGAL_WR;
        end
        return cls;
    endfunction

endpackage : bank_mem_pkg
`default_nettype wire

// File: rtl/bank_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : bank_mem_responder_if
// Purpose  : Request/response bundle between the cache controller (master)
//            and the banked memory responder (slave).
// Signals  : addr, data_in, wr, rd        (controller -> memory)
//            data_out, stall, busy, err    (memory -> controller)
//            rd_count, wr_count, stall_count (memory -> controller, only
//            when BANK_MEM_PERF_EN is defined)
// Macro    : BANK_MEM_PERF_EN
// Revision : 1.0 - initial release
// ============================================================================
interface bank_mem_responder_if
    import bank_mem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);

    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data_in;
    logic                 wr;
    logic                 rd;
    logic [DATA_W-1:0]    data_out;
    logic                 stall;
    logic [NUM_BANKS-1:0] busy;
    logic                 err;

`ifdef BANK_MEM_PERF_EN
    logic [15:0]          rd_count;
    logic [15:0]          wr_count;
    logic [15:0]          stall_count;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, stall, busy, err,
        input  rd_count, wr_count, stall_count
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, stall, busy, err,
        output rd_count, wr_count, stall_count
    );
`else
    modport master (
        output addr, data_in, wr, rd,
        input  data_out, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, stall, busy, err
    );
`endif

endinterface : bank_mem_responder_if
`default_nettype wire

// File: rtl/bank_mem_responder_busy_ctr.sv
`default_nettype none
// ============================================================================
// Module   : bank_busy_ctr
// Purpose  : Per-bank busy window. Loads a count when the bank accepts a
//            request, then counts down once per cycle to zero.
// Ports    : clk, rst_n    - clock / async active-low reset
//            load          - bank accepted a request this cycle
//            load_val      - remaining busy cycles after acceptance
//            busy          - registered, count is nonzero
//            zero          - registered, count is zero (bank can accept)
// Revision : 1.0 - initial release
// ============================================================================
module bank_busy_ctr #(
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    output logic                  busy,
    output logic                  zero
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_busy;

    // A load only happens when the count is already zero, so load and
    // decrement never compete.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (load) begin
            w_cnt_nxt = load_val;
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end
    end

    // The busy flag tracks the next count so it is a flop output rather
    // than a compare on the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt != '0);
        end
    end

    assign busy = r_busy;
    assign zero = ~r_busy;

endmodule : bank_busy_ctr
`default_nettype wire

// File: rtl/bank_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : bank_mem_responder
// Purpose  : Four-bank word-interleaved single-ported memory serving line
//            fills and writebacks. One request per cycle; a request to a
//            bank still in its busy window is stalled; read data returns
//            two cycles after acceptance; illegal requests flag err.
// Ports    : clk           - clock, rising edge
//            rst_n         - asynchronous active-low reset
//            bus (slave)   - addr, data_in, wr, rd, data_out, stall, busy,
//                            err (+ rd_count, wr_count, stall_count)
// Macro    : BANK_MEM_PERF_EN - adds saturating request/stall counters
// Revision : 1.0 - initial release
// ============================================================================
module bank_mem_responder
    import bank_mem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int MEM_AW      = 11,
    parameter int BANK_CYCLES = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    bank_mem_responder_if.slave bus
);

    localparam int              CNT_W      = 4;
    localparam logic [CNT_W-1:0] c_load_val = CNT_W'(BANK_CYCLES - 1);
    localparam int              MEM_WORDS  = 1 << MEM_AW;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    req_class_e           w_req_class;
    logic [1:0]           w_bank;
    logic [MEM_AW-1:0]    w_idx;
    logic                 w_legal;
    logic                 w_bank_free;
    logic                 w_accept;
    logic                 w_rd_accept;
    logic                 w_wr_accept;
    logic [NUM_BANKS-1:0] w_zero;
    logic [NUM_BANKS-1:0] w_busy;
    logic [NUM_BANKS-1:0] w_load;
    logic                 w_unused_addr;

    assign w_req_class = classify(bus.rd, bus.wr, bus.addr[0]);
    assign w_bank      = bank_sel(bus.addr[2:0]);
    assign w_idx       = bus.addr[MEM_AW:1];
    assign w_legal     = (w_req_class == LEGAL_RD) || (w_req_class == LEGAL_WR);
    assign w_bank_free = w_zero[w_bank];
    assign w_accept    = w_legal & w_bank_free;
    assign w_rd_accept = w_accept & (w_req_class == LEGAL_RD);
    assign w_wr_accept = w_accept & (w_req_class == LEGAL_WR);

    // Upper address bits alias onto the same storage.
    assign w_unused_addr = ^bus.addr[ADDR_W-1:MEM_AW+1];

    // ------------------------------------------------------------------
    // Per-bank busy windows
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        assign w_load[gi] = w_accept & (w_bank == 2'(gi));

        bank_busy_ctr #(
            .CNT_W    (CNT_W)
        ) u_busy_ctr (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (w_load[gi]),
            .load_val (c_load_val),
            .busy     (w_busy[gi]),
            .zero     (w_zero[gi])
        );
    end

    // ------------------------------------------------------------------
    // Storage and read pipe data path (not reset; validity is tracked
    // separately so stale words never reach data_out)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_mem [0:MEM_WORDS-1];
    logic [DATA_W-1:0] r_s1_data;
    logic [DATA_W-1:0] r_s2_data;

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[w_idx] <= bus.data_in;
        end
        if (w_rd_accept) begin
            r_s1_data <= r_mem[w_idx];
        end
        r_s2_data <= r_s1_data;
    end

    // ------------------------------------------------------------------
    // Read pipe valids and error flag
    // ------------------------------------------------------------------
    logic r_s1_vld;
    logic r_s2_vld;
    logic r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_s1_vld <= w_rd_accept;
            r_s2_vld <= r_s1_vld;
            r_err    <= (w_req_class == ILLEGAL);
        end
    end

    assign bus.data_out = r_s2_vld ? r_s2_data : '0;
    assign bus.stall    = w_legal & ~w_bank_free;
    assign bus.busy     = w_busy;
    assign bus.err      = r_err;

`ifdef BANK_MEM_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_count    <= '0;
            r_wr_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_rd_accept && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_wr_accept && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
            if (bus.stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign bus.rd_count    = r_rd_count;
    assign bus.wr_count    = r_wr_count;
    assign bus.stall_count = r_stall_count;
`endif

endmodule : bank_mem_responder
`default_nettype wire
